// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: architectural register-zero index and default widths.
// No logic; no latency or backpressure.
package mips_pkg;
    localparam int REG_ZERO         = 0;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file bus: two write ports, NUM_RD flattened read ports and the busy-set request.
// Latency and flow are set by reg_file_mp; the bus has no handshake and is always accepted.
interface reg_file_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     reg_write_en0;
    logic [AW-1:0]            write_reg0;
    logic [DATA_W-1:0]        write_data0;
    logic                     reg_write_en1;
    logic [AW-1:0]            write_reg1;
    logic [DATA_W-1:0]        write_data1;
    logic [NUM_RD*AW-1:0]     read_reg;
    logic [NUM_RD*DATA_W-1:0] read_data;
    logic                     busy_set_en;
    logic [AW-1:0]            busy_set_reg;
    logic [NUM_RD-1:0]        read_busy;

    modport master (
        output reg_write_en0, write_reg0, write_data0,
        output reg_write_en1, write_reg1, write_data1,
        output read_reg, busy_set_en, busy_set_reg,
        input  read_data, read_busy
    );

    modport slave (
        input  reg_write_en0, write_reg0, write_data0,
        input  reg_write_en1, write_reg1, write_data1,
        input  read_reg, busy_set_en, busy_set_reg,
        output read_data, read_busy
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits: set at decode, cleared by writeback, set beats clear; lookup is combinational.
// Updates 1 cycle after the request; always ready, no backpressure.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set_en,
    input  logic [AW-1:0]        i_set_reg,
    input  logic                 i_clr_en0,
    input  logic [AW-1:0]        i_clr_reg0,
    input  logic                 i_clr_en1,
    input  logic [AW-1:0]        i_clr_reg1,
    input  logic [NUM_RD*AW-1:0] i_rd_reg,
    output logic [NUM_RD-1:0]    o_rd_busy
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Set is applied last: a new producer issued this cycle outranks the one retiring.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en0) w_busy_nxt[i_clr_reg0] = 1'b0;
        if (i_clr_en1) w_busy_nxt[i_clr_reg1] = 1'b0;
        if (i_set_en && i_set_reg != AW'(REG_ZERO)) w_busy_nxt[i_set_reg] = 1'b1;
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign o_rd_busy[k] = r_busy[i_rd_reg[k*AW +: AW]];
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: dual write (port 1 wins collisions), NUM_RD combinational reads, optional bypass, busy scoreboard.
// Write latency 1 cycle, read latency 0; no backpressure, every request is accepted.
module reg_file_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we0;
    logic              w_we1;

    // Gating with rst_n keeps bypass from leaking write data while reset is held.
    assign w_we0 = rst_n && bus.reg_write_en0 && (bus.write_reg0 != AW'(REG_ZERO));
    assign w_we1 = rst_n && bus.reg_write_en1 && (bus.write_reg1 != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_we0) r_regs[bus.write_reg0] <= bus.write_data0;
            if (w_we1) r_regs[bus.write_reg1] <= bus.write_data1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     w_idx;
        logic [DATA_W-1:0] w_dat;

        assign w_idx = bus.read_reg[k*AW +: AW];

        always_comb begin
            w_dat = r_regs[w_idx];
            if (BYPASS != 0) begin
                if (w_we0 && w_idx == bus.write_reg0) w_dat = bus.write_data0;
                if (w_we1 && w_idx == bus.write_reg1) w_dat = bus.write_data1;
            end
        end

        assign bus.read_data[k*DATA_W +: DATA_W] = w_dat;

        if ((1 << AW) != NUM_REGS) begin : g_chk
            always @(posedge clk) if (rst_n) assert (int'(w_idx) < NUM_REGS);
        end
    end

    if ((1 << AW) != NUM_REGS) begin : g_wchk
        always @(posedge clk) begin
            if (rst_n && bus.reg_write_en0) assert (int'(bus.write_reg0) < NUM_REGS);
            if (rst_n && bus.reg_write_en1) assert (int'(bus.write_reg1) < NUM_REGS);
            if (rst_n && bus.busy_set_en)   assert (int'(bus.busy_set_reg) < NUM_REGS);
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (bus.busy_set_en),
        .i_set_reg  (bus.busy_set_reg),
        .i_clr_en0  (w_we0),
        .i_clr_reg0 (bus.write_reg0),
        .i_clr_en1  (w_we1),
        .i_clr_reg1 (bus.write_reg1),
        .i_rd_reg   (bus.read_reg),
        .o_rd_busy  (bus.read_busy)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default/bypass, no-bypass and 64-bit/16-reg/4-port instances.
// Expected values are queued at stimulus time and popped when the output is sampled.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifa ();
    reg_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifb ();
    reg_file_mp_if #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) ifc ();

    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    reg_file_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    logic [63:0] exp_q [$];
    string       tag_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic push(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rd_a(input int k);
        return {32'd0, ifa.read_data[k*32 +: 32]};
    endfunction

    function automatic logic [63:0] rd_b(input int k);
        return {32'd0, ifb.read_data[k*32 +: 32]};
    endfunction

    function automatic logic [63:0] rd_c(input int k);
        return ifc.read_data[k*64 +: 64];
    endfunction

    task automatic idle_all();
        ifa.reg_write_en0 = 0; ifa.write_reg0 = '0; ifa.write_data0 = '0;
        ifa.reg_write_en1 = 0; ifa.write_reg1 = '0; ifa.write_data1 = '0;
        ifa.busy_set_en = 0; ifa.busy_set_reg = '0;
        ifb.reg_write_en0 = 0; ifb.write_reg0 = '0; ifb.write_data0 = '0;
        ifb.reg_write_en1 = 0; ifb.write_reg1 = '0; ifb.write_data1 = '0;
        ifb.busy_set_en = 0; ifb.busy_set_reg = '0;
        ifc.reg_write_en0 = 0; ifc.write_reg0 = '0; ifc.write_data0 = '0;
        ifc.reg_write_en1 = 0; ifc.write_reg1 = '0; ifc.write_data1 = '0;
        ifc.busy_set_en = 0; ifc.busy_set_reg = '0;
    endtask

    initial begin
        idle_all();
        ifa.read_reg = {5'd1, 5'd1};
        ifb.read_reg = '0;
        ifc.read_reg = '0;

        // Reset state
        tick(); tick();
        push("reset_read_data", 64'd0);  check({32'd0, ifa.read_data});
        push("reset_read_busy", 64'd0);  check({62'd0, ifa.read_busy});
        rst_n = 1'b1;

        // Basic write / read on both ports
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd1; ifa.write_data0 = 32'd42;
        push("wr1_p0", 64'd42); push("wr1_p1", 64'd42);
        tick();
        ifa.reg_write_en0 = 0;
        check(rd_a(0)); check(rd_a(1));

        // Write to $0 is dropped, also under bypass
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd0; ifa.write_data0 = 32'd99;
        ifa.read_reg = {5'd0, 5'd0};
        #1 push("r0_bypass", 64'd0); check(rd_a(0));
        tick();
        ifa.reg_write_en0 = 0;
        push("r0_after", 64'd0); check(rd_a(1));

        // Collision on $5: port 1 wins both forwarded and stored
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd5; ifa.write_data0 = 32'h11;
        ifa.reg_write_en1 = 1; ifa.write_reg1 = 5'd5; ifa.write_data1 = 32'h22;
        ifa.read_reg = {5'd5, 5'd5};
        #1 push("collide_bypass", 64'h22); check(rd_a(0));
        tick();
        ifa.reg_write_en0 = 0; ifa.reg_write_en1 = 0;
        push("collide_stored", 64'h22); check(rd_a(1));

        // Distinct indices on both write ports
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd6; ifa.write_data0 = 32'd7;
        ifa.reg_write_en1 = 1; ifa.write_reg1 = 5'd7; ifa.write_data1 = 32'd8;
        ifa.read_reg = {5'd7, 5'd6};
        push("dual_r6", 64'd7); push("dual_r7", 64'd8);
        tick();
        ifa.reg_write_en0 = 0; ifa.reg_write_en1 = 0;
        check(rd_a(0)); check(rd_a(1));

        // Same-cycle bypass (dut_a) versus no bypass (dut_b)
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd3; ifa.write_data0 = 32'hDEAD;
        ifb.reg_write_en0 = 1; ifb.write_reg0 = 5'd3; ifb.write_data0 = 32'hDEAD;
        ifa.read_reg = {5'd3, 5'd3};
        ifb.read_reg = {5'd3, 5'd3};
        #1;
        push("bypass1_before", 64'hDEAD); check(rd_a(0));
        push("bypass0_before", 64'h0);    check(rd_b(0));
        tick();
        ifa.reg_write_en0 = 0; ifb.reg_write_en0 = 0;
        push("bypass1_after", 64'hDEAD); check(rd_a(1));
        push("bypass0_after", 64'hDEAD); check(rd_b(1));

        // Scoreboard: set, clear, set-beats-clear, $0 ignored
        ifa.read_reg = {5'd4, 5'd4};
        ifa.busy_set_en = 1; ifa.busy_set_reg = 5'd4;
        push("sb_set", 64'd3);
        tick();
        ifa.busy_set_en = 0;
        check({62'd0, ifa.read_busy});
        ifa.reg_write_en1 = 1; ifa.write_reg1 = 5'd4; ifa.write_data1 = 32'h44;
        #1 push("sb_clr_before_edge", 64'd3); check({62'd0, ifa.read_busy});
        tick();
        ifa.reg_write_en1 = 0;
        push("sb_clr", 64'd0); check({62'd0, ifa.read_busy});
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd4; ifa.write_data0 = 32'h45;
        ifa.busy_set_en = 1; ifa.busy_set_reg = 5'd4;
        tick();
        ifa.reg_write_en0 = 0;
        ifa.busy_set_reg = 5'd0;
        push("sb_set_wins", 64'd3); check({62'd0, ifa.read_busy});
        ifa.read_reg = {5'd4, 5'd0};
        tick();
        ifa.busy_set_en = 0;
        push("sb_r0", 64'd2); check({62'd0, ifa.read_busy});

        // Asynchronous reset mid-cycle
        ifa.read_reg = {5'd4, 5'd1};
        #2;
        push("pre_reset_r1", 64'd42); check(rd_a(0));
        rst_n = 1'b0;
        #1;
        push("async_reset_r1", 64'd0);  check(rd_a(0));
        push("async_reset_busy", 64'd0); check({62'd0, ifa.read_busy});
        ifa.reg_write_en0 = 1; ifa.write_reg0 = 5'd2; ifa.write_data0 = 32'd5;
        ifa.read_reg = {5'd1, 5'd2};
        #1 push("reset_no_bypass", 64'd0); check(rd_a(0));
        tick(); tick();
        rst_n = 1'b1;
        ifa.reg_write_en0 = 0;
        #1;
        push("reset_write_ignored", 64'd0); check(rd_a(0));
        push("reset_cleared_r1", 64'd0);    check(rd_a(1));

        // Wide, 16-register, 4-read-port instance
        ifc.reg_write_en1 = 1; ifc.write_reg1 = 4'd15; ifc.write_data1 = 64'hFFFF_FFFF_0000_0001;
        ifc.read_reg = {4{4'd15}};
        for (int k = 0; k < 4; k++) push($sformatf("wide_p%0d", k), 64'hFFFF_FFFF_0000_0001);
        tick();
        ifc.reg_write_en1 = 0;
        for (int k = 0; k < 4; k++) check(rd_c(k));

        if (exp_q.size() != 0) begin
            n_errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the MIPS datapath. It is the next generation of the single-write, two-read reg_file.
- Adds a configurable read-port count and a second write port for dual writeback (e.g. ALU plus load).
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >= 2)
AW, $clog2(NUM_REGS), register index width (derived; not overridden)
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the stored value

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
reg_write_en0  in  1  write enable, port 0
write_reg0  in  AW  write index, port 0
write_data0  in  DATA_W  write data, port 0
reg_write_en1  in  1  write enable, port 1
write_reg1  in  AW  write index, port 1
write_data1  in  DATA_W  write data, port 1
read_reg  in  NUM_RD*AW  flattened read indices; port k occupies bits [k*AW +: AW]
read_data  out  NUM_RD*DATA_W  flattened read data; port k occupies bits [k*DATA_W +: DATA_W]
busy_set_en  in  1  mark a register as pending a write
busy_set_reg  in  AW  register to mark pending
read_busy  out  NUM_RD  busy bit of each read port's register

Behaviour:
- Reset (rst_n=0, asynchronous): all registers clear to 0 and all busy bits clear immediately. While reset is held, read_data is all 0 and read_busy is all 0. Writes and sets are ignored while rst_n=0. Reset release is synchronised by the caller.
- Register 0 is hardwired to 0:
  - Writes to index 0 are dropped.
  - Reads of index 0 always return 0, including under bypass.
  - busy_set for index 0 is ignored, so read_busy for index 0 is always 0.
- Writes: at the rising clk edge, for each port p with reg_write_en_p=1 and write_reg_p!=0, the register is updated with write_data_p. Write latency is 1 cycle.
- Dual-write collision (both enables set, same nonzero index): port 1 wins. Port 0's data is discarded.
- Reads are combinational (0-cycle) and independent per port. Any number of ports may read the same index.
- Bypass, BYPASS=1: if read index == write_reg_p with the enable set and index != 0, read_data returns write_data_p in the same cycle. If both write ports match, port 1 is forwarded. With BYPASS=0 the read returns the pre-edge value and the new value appears after the edge.
- Scoreboard, one busy bit per register, updated at clk edge:
  - busy_set_en with a nonzero index sets that register's bit.
  - An enabled write to index r clears busy[r].
  - Set and clear of the same r in the same cycle: set wins, because a new producer was issued after the retiring one.
  - Setting an already-busy register keeps it busy. There is no counting.
- read_busy[k] = busy[read index k]. It has no bypass: a bit being cleared this cycle still reads 1 until the edge.
- Out-of-range indices (only possible if NUM_REGS is not a power of 2) are illegal. An assertion must fire.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO index constant
  - default DATA_W and NUM_REGS
  - a reg_idx_t typedef, if the codebase uses SV
- One natural sub-module: reg_scoreboard (busy bit vector with set/clear priority, per-port lookup). The storage array, collision logic and bypass muxes stay in reg_file_mp.

Test Plan:
- Reset then read: assert rst_n=0 mid-run after writing 42 to $1 -> read_data for $1 is 0 immediately, without waiting for a clk edge; read_busy is 0.
- Basic write/read: we0 writes 42 to $1, then read port 0 on $1 and port 1 on $1 -> both return 42 one cycle later. A write of 99 to $0 -> read of $0 returns 0.
- Dual-write collision: port 0 writes 0x11 to $5 and port 1 writes 0x22 to $5 in the same cycle -> $5 reads 0x22. Different indices ($6=7, $7=8) -> both land.
- Bypass: with BYPASS=1, write 0xDEAD to $3 and read $3 in the same cycle -> read_data returns 0xDEAD before the edge. Rerun with BYPASS=0 -> old value before the edge, 0xDEAD after.
- Scoreboard: set $4 -> read_busy=1 on the next cycle. Write $4 -> busy is 0 after the edge. Set and write $4 in the same cycle -> busy stays 1. Set $0 -> busy stays 0.
- Parametrisation: NUM_RD=4, DATA_W=64, NUM_REGS=16 -> write 0xFFFF_FFFF_0000_0001 to $15 -> all 4 ports read it back correctly.
